fir_channel_arbiter: RTL and testbench
======================================

Name: fir_channel_arbiter

Overview:
- Shares one `fir_filter_direct_form_partially_pipelined` instance between two word-level requester channels. Each channel has its own deserializer upstream and serializer downstream.
- Input side: round-robin arbitration onto the FIR input handshake. Each accepted word pushes a channel tag into a tag FIFO.
- Output side: each FIR result is routed to the channel at the head of the tag FIFO. FIR outputs return strictly in input order.

Parameters:
- DATA_WIDTH, 16, word width of all data buses.
- TAG_DEPTH, 8, tag FIFO entries; power of two; at least the FIR's maximum outstanding words.
- CNT_WIDTH, 4, width of the outstanding-count status; must hold TAG_DEPTH.

Ports:
- i_clk  in  1  system clock (sys_clk domain)
- i_rst  in  1  reset, synchronous, active-high
- i_en  in  1  global enable; low freezes all transfers
- iv_din0 / iv_din1  in  DATA_WIDTH  channel 0/1 input word
- i_din0_valid / i_din1_valid  in  1  channel 0/1 input valid
- o_ready0 / o_ready1  out  1  channel 0/1 input accepted this cycle
- ov_fir_din  out  DATA_WIDTH  word to FIR
- o_fir_din_valid  out  1  FIR input valid
- i_fir_ready  in  1  FIR o_ready
- iv_fir_dout  in  DATA_WIDTH  FIR result
- i_fir_dout_valid  in  1  FIR o_dout_valid
- o_fir_ready  out  1  to FIR i_ready
- ov_dout0 / ov_dout1  out  DATA_WIDTH  routed result to channel 0/1 serializer
- o_dout0_valid / o_dout1_valid  out  1  routed result valid
- i_ready0 / i_ready1  in  1  channel 0/1 serializer o_ready
- ov_outstanding  out  CNT_WIDTH  tag FIFO occupancy
- o_err  out  1  sticky orphan-result error

Behaviour:
- Handshakes are valid/ready. A transfer occurs in a cycle where both are high. Valid never depends combinationally on ready of the same interface.
- Reset (i_rst=1 at a clock edge):
  - Round-robin pointer becomes channel 1 as last-granted, so channel 0 wins first.
  - Tag FIFO becomes empty (rd_ptr = wr_ptr = 0, count = 0); ov_outstanding = 0; o_err = 0.
  - All valid/ready outputs are 0 while i_rst is high.
  - Reset mid-operation discards all tags. The FIR shares i_rst, so its pipeline is flushed in the same cycle.
- Input arbitration (combinational from the registered pointer):
  - req0 = i_din0_valid; req1 = i_din1_valid.
  - Only one requesting: grant it. Both requesting: grant the channel not granted last. Neither: no grant.
  - can_push = i_en & (count < TAG_DEPTH).
  - o_fir_din_valid = can_push & (req0 | req1); ov_fir_din = granted channel's word. ov_fir_din is 0 when there is no grant.
  - o_readyN = (grant == N) & o_fir_din_valid & i_fir_ready.
  - On an input transfer: push the grant bit into the tag FIFO and update the last-granted pointer. The pointer holds when there is no transfer.
  - Full FIFO blocks the push even if a pop occurs in the same cycle (no bypass).
- Output routing:
  - head = tag at rd_ptr; nonempty = (count != 0).
  - o_doutN_valid = i_en & nonempty & (head == N) & i_fir_dout_valid.
  - ov_doutN = iv_fir_dout when head == N, else 0.
  - o_fir_ready = i_en & nonempty & i_ready[head].
  - On an output transfer (i_fir_dout_valid & o_fir_ready): pop the tag.
- Count update:
  - push only: +1; pop only: −1; both: unchanged. Pointers wrap modulo TAG_DEPTH.
  - Pop on empty cannot occur by construction.
- Error handling: i_fir_dout_valid & i_en & ~nonempty sets o_err. o_err stays 1 until reset. o_fir_ready stays 0, so the FIR holds the result.
- i_en = 0: no push, no pop, pointer and count held, all valid/ready outputs 0.
- Latency: arbiter adds 0 cycles on both paths (combinational mux). Tag and pointer state is registered.

Test Plan:
- Single channel: ch0 sends 0x0001,0x0002,0x0003 with i_fir_ready=1 and ch1 idle. Expect 3 consecutive grants to ch0 and ov_outstanding increments 1,2,3. FIR results appear only on ov_dout0 in order; ch1 valid never asserts.
- Fairness: both channels valid continuously, ch0=0x00A0.., ch1=0x00B0... Expect FIR input order A0,B0,A1,B1,... and results alternate dout0/dout1 in matching order.
- Backpressure out: i_ready1=0 while the head tag is 1. Expect o_fir_ready=0 and the FIR stalls. Ch0 results queued behind are not emitted early. Releasing i_ready1 drains in order.
- Full FIFO: i_fir_dout_valid held 0, both channels sending. Expect exactly 8 pushes, then o_fir_din_valid=0 with ov_outstanding=8. One pop allows one push on the following cycle, not the same cycle.
- Reset mid-stream: assert i_rst with ov_outstanding=5. Next cycle ov_outstanding=0, all valids 0, first grant after release goes to ch0.
- Orphan result: after reset, force i_fir_dout_valid=1 with the FIFO empty. Expect o_err=1 next cycle and o_fir_ready=0; o_err persists until i_rst.

Source files
------------

// File: rtl/fir_channel_arbiter.sv
// Shares one FIR between two word channels: round-robin onto the FIR input, tag-FIFO routing of results.
// Zero added latency on both paths; a full tag FIFO or a stalled head-channel serializer backpressures the FIR.
module fir_channel_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_DEPTH  = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] iv_din0,
  input  logic [DATA_WIDTH-1:0] iv_din1,
  input  logic                  i_din0_valid,
  input  logic                  i_din1_valid,
  output logic                  o_ready0,
  output logic                  o_ready1,
  output logic [DATA_WIDTH-1:0] ov_fir_din,
  output logic                  o_fir_din_valid,
  input  logic                  i_fir_ready,
  input  logic [DATA_WIDTH-1:0] iv_fir_dout,
  input  logic                  i_fir_dout_valid,
  output logic                  o_fir_ready,
  output logic [DATA_WIDTH-1:0] ov_dout0,
  output logic [DATA_WIDTH-1:0] ov_dout1,
  output logic                  o_dout0_valid,
  output logic                  o_dout1_valid,
  input  logic                  i_ready0,
  input  logic                  i_ready1,
  output logic [CNT_WIDTH-1:0]  ov_outstanding,
  output logic                  o_err
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(TAG_DEPTH);

  logic [TAG_DEPTH-1:0] tag_q;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 last_grant;
  logic                 err_q;

  logic live;
  logic any_req;
  logic grant;
  logic can_push;
  logic push;
  logic pop;
  logic nonempty;
  logic head;
  logic head_ready;

  // Reset forces every valid/ready low, so fold it into the enable.
  assign live = i_en & ~i_rst;

  // Both requesting: the channel not granted last wins.
  always_comb begin
    grant = 1'b0;
    if (i_din0_valid && i_din1_valid) begin
      grant = ~last_grant;
    end else if (i_din1_valid) begin
      grant = 1'b1;
    end
  end

  assign any_req         = i_din0_valid | i_din1_valid;
  assign can_push        = live & (count < DEPTH_CNT);
  assign o_fir_din_valid = can_push & any_req;
  assign push            = o_fir_din_valid & i_fir_ready;
  assign o_ready0        = push & ~grant;
  assign o_ready1        = push & grant;

  always_comb begin
    ov_fir_din = '0;
    if (any_req) begin
      ov_fir_din = grant ? iv_din1 : iv_din0;
    end
  end

  assign nonempty   = (count != '0);
  assign head       = tag_q[rd_ptr];
  assign head_ready = head ? i_ready1 : i_ready0;

  assign o_fir_ready   = live & nonempty & head_ready;
  assign o_dout0_valid = live & nonempty & ~head & i_fir_dout_valid;
  assign o_dout1_valid = live & nonempty & head & i_fir_dout_valid;
  assign ov_dout0      = head ? '0 : iv_fir_dout;
  assign ov_dout1      = head ? iv_fir_dout : '0;
  assign pop           = i_fir_dout_valid & o_fir_ready;

  assign ov_outstanding = count;
  assign o_err          = err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr] <= grant;
        wr_ptr        <= wr_ptr + PTR_W'(1);
        last_grant    <= grant;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
      // A result with no tag to route it is unrecoverable until reset.
      if (i_fir_dout_valid && i_en && !nonempty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_channel_arbiter.sv
// Randomized bench for fir_channel_arbiter: the bench plays the FIR, a queue model predicts grants and routing.
module tb_fir_channel_arbiter;

  localparam int DW = 16;
  localparam int DEPTH = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_en;
  logic [DW-1:0] iv_din0, iv_din1;
  logic          i_din0_valid, i_din1_valid;
  logic          o_ready0, o_ready1;
  logic [DW-1:0] ov_fir_din;
  logic          o_fir_din_valid;
  logic          i_fir_ready;
  logic [DW-1:0] iv_fir_dout;
  logic          i_fir_dout_valid;
  logic          o_fir_ready;
  logic [DW-1:0] ov_dout0, ov_dout1;
  logic          o_dout0_valid, o_dout1_valid;
  logic          i_ready0, i_ready1;
  logic [3:0]    ov_outstanding;
  logic          o_err;

  fir_channel_arbiter #(.DATA_WIDTH(DW), .TAG_DEPTH(DEPTH), .CNT_WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
    .iv_din0(iv_din0), .iv_din1(iv_din1),
    .i_din0_valid(i_din0_valid), .i_din1_valid(i_din1_valid),
    .o_ready0(o_ready0), .o_ready1(o_ready1),
    .ov_fir_din(ov_fir_din), .o_fir_din_valid(o_fir_din_valid), .i_fir_ready(i_fir_ready),
    .iv_fir_dout(iv_fir_dout), .i_fir_dout_valid(i_fir_dout_valid), .o_fir_ready(o_fir_ready),
    .ov_dout0(ov_dout0), .ov_dout1(ov_dout1),
    .o_dout0_valid(o_dout0_valid), .o_dout1_valid(o_dout1_valid),
    .i_ready0(i_ready0), .i_ready1(i_ready1),
    .ov_outstanding(ov_outstanding), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int fails   = 0;

  // Reference state: channel order of words inside the FIR, FIR contents, expected results per channel.
  int            tags[$];
  logic [DW-1:0] fir_q[$];
  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];
  int            m_last = 1;
  bit            m_err  = 0;
  bit            orphan_mode = 0;

  function automatic logic [DW-1:0] fres(input logic [DW-1:0] w);
    return DW'(w * 3 + 16'h1234);
  endfunction

  function automatic bit pr(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: check combinational outputs against the pre-edge state, then advance it.
  always @(negedge i_clk) begin
    bit run_ok, req0, req1, can, fdv, r0, r1, ne, fr, dv0, dv1;
    int g, head;
    logic [DW-1:0] fdin, w;
    run_ok = i_en && !i_rst;
    req0 = i_din0_valid;
    req1 = i_din1_valid;
    if (req0 && req1) g = 1 - m_last;
    else g = req1 ? 1 : 0;
    can  = run_ok && (tags.size() < DEPTH);
    fdv  = can && (req0 || req1);
    r0   = fdv && i_fir_ready && (g == 0);
    r1   = fdv && i_fir_ready && (g == 1);
    fdin = (req0 || req1) ? ((g == 1) ? iv_din1 : iv_din0) : '0;
    ne   = tags.size() != 0;
    head = ne ? tags[0] : -1;
    fr   = run_ok && ne && ((head == 1) ? i_ready1 : i_ready0);
    dv0  = run_ok && ne && (head == 0) && i_fir_dout_valid;
    dv1  = run_ok && ne && (head == 1) && i_fir_dout_valid;

    chk("fir_din_valid", o_fir_din_valid, fdv);
    chk("ready0", o_ready0, r0);
    chk("ready1", o_ready1, r1);
    chk("fir_din", ov_fir_din, fdin);
    chk("fir_ready", o_fir_ready, fr);
    chk("dout0_valid", o_dout0_valid, dv0);
    chk("dout1_valid", o_dout1_valid, dv1);
    chk("outstanding", ov_outstanding, tags.size());
    chk("err", o_err, m_err);
    if (ne) begin
      chk("dout0_mux", ov_dout0, (head == 0) ? iv_fir_dout : '0);
      chk("dout1_mux", ov_dout1, (head == 1) ? iv_fir_dout : '0);
    end

    if (i_rst) begin
      tags.delete(); fir_q.delete(); exp0.delete(); exp1.delete();
      m_last = 1;
      m_err  = 0;
    end else begin
      if (i_fir_dout_valid && i_en && !ne) m_err = 1;
      if (i_fir_dout_valid && fr) begin
        void'(tags.pop_front());
        void'(fir_q.pop_front());
      end
      if (r0 || r1) begin
        w = (g == 1) ? iv_din1 : iv_din0;
        tags.push_back(g);
        fir_q.push_back(w);
        if (g == 1) exp1.push_back(fres(w));
        else exp0.push_back(fres(w));
        m_last = g;
      end
    end
  end

  // Output monitor: every routed result must be the next one expected on that channel.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_dout0_valid && i_ready0) begin
        if (exp0.size() == 0) chk("dout0_unexpected", 1, 0);
        else chk("dout0_data", ov_dout0, exp0.pop_front());
      end
      if (o_dout1_valid && i_ready1) begin
        if (exp1.size() == 0) chk("dout1_unexpected", 1, 0);
        else chk("dout1_data", ov_dout1, exp1.pop_front());
      end
    end
  end

  task automatic run(input int n, input int pen, input int pv0, input int pv1, input int pfr,
                     input int pdv, input int prd0, input int prd1);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
      i_en         = pr(pen);
      i_din0_valid = pr(pv0);
      i_din1_valid = pr(pv1);
      iv_din0      = {4'hA, 12'($urandom)};
      iv_din1      = {4'hB, 12'($urandom)};
      i_fir_ready  = pr(pfr);
      i_ready0     = pr(prd0);
      i_ready1     = pr(prd1);
      if (orphan_mode) begin
        i_fir_dout_valid = 1'b1;
        iv_fir_dout      = 16'($urandom);
      end else if (fir_q.size() != 0 && pr(pdv)) begin
        i_fir_dout_valid = 1'b1;
        iv_fir_dout      = fres(fir_q[0]);
      end else begin
        i_fir_dout_valid = 1'b0;
        iv_fir_dout      = 16'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    i_en = 1'b1; i_din0_valid = 1'b1; i_din1_valid = 1'b1; i_fir_ready = 1'b1;
    i_ready0 = 1'b1; i_ready1 = 1'b1;
    i_fir_dout_valid = (fir_q.size() != 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_din0_valid = 1'b0; i_din1_valid = 1'b0; i_fir_dout_valid = 1'b0;
  endtask

  task automatic drain();
    run(60, 100, 0, 0, 100, 100, 100, 100);
    chk("drained_outstanding", ov_outstanding, 0);
    chk("drained_exp0", exp0.size(), 0);
    chk("drained_exp1", exp1.size(), 0);
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0;
    iv_din0 = '0; iv_din1 = '0; i_din0_valid = 1'b0; i_din1_valid = 1'b0;
    i_fir_ready = 1'b0; iv_fir_dout = '0; i_fir_dout_valid = 1'b0;
    i_ready0 = 1'b0; i_ready1 = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Single channel 0x0001..0x0003 with ch1 idle.
    for (int k = 1; k <= 3; k++) begin
      @(posedge i_clk); #1;
      i_en = 1'b1; i_din0_valid = 1'b1; iv_din0 = DW'(k); i_din1_valid = 1'b0;
      i_fir_ready = 1'b1; i_fir_dout_valid = 1'b0; i_ready0 = 1'b1; i_ready1 = 1'b1;
    end
    drain();

    run(40, 100, 100, 100, 100, 60, 100, 100);   // fairness
    drain();
    run(40, 100, 100, 100, 100, 100, 100, 0);    // ch1 serializer stalled
    run(10, 100, 0, 0, 100, 100, 100, 100);
    drain();

    run(14, 100, 100, 100, 100, 0, 100, 100);    // fill the tag FIFO
    chk("full_outstanding", ov_outstanding, DEPTH);
    run(1, 100, 100, 100, 100, 100, 100, 100);   // pop with full FIFO: no same-cycle push
    run(2, 100, 100, 100, 100, 0, 100, 100);
    drain();

    run(300, 80, 60, 60, 70, 60, 70, 70);        // mixed random traffic incl. enable gaps
    drain();

    // Reset with five words outstanding.
    for (int k = 0; k < 20 && tags.size() < 5; k++) run(1, 100, 100, 100, 100, 0, 100, 100);
    chk("pre_reset_outstanding", tags.size(), 5);
    do_reset();
    run(6, 100, 100, 100, 100, 50, 100, 100);
    drain();

    // Orphan result.
    do_reset();
    orphan_mode = 1'b1;
    run(4, 100, 0, 0, 100, 100, 100, 100);
    orphan_mode = 1'b0;
    run(2, 100, 0, 0, 100, 0, 100, 100);
    chk("err_sticky", o_err, 1);
    do_reset();
    run(2, 100, 0, 0, 100, 0, 100, 100);
    chk("err_cleared", o_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
